// File: rtl/uart_arb_pkg.sv
// Shared constants for the uart_tx arbiter: FSM state encoding, tag byte base
// and a small state-decode helper.
package uart_arb_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_DRAIN     = 3'd2;
    localparam logic [2:0] ST_TAG_SEND  = 3'd3;
    localparam logic [2:0] ST_TAG_DRAIN = 3'd4;

    localparam logic [7:0] TAG_BASE = 8'hA0;

    // States in which a byte is offered to uart_tx and the ack timer runs.
    function automatic logic is_send_state(input logic [2:0] s);
        return (s == ST_SEND) || (s == ST_TAG_SEND);
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: the first asserted request at or after
// (last + 1) mod NUM_REQ wins.
module uart_rr_arb #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               any_req
);

    int cand;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        cand    = 0;
        idx     = '0;
        any_req = |req;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(last) + off) % NUM_REQ;
            if (req[cand]) idx = IW'(cand);
        end
        grant = any_req ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among NUM_REQ requesters, one byte in flight at a time.
// Define UART_ARB_TAG_EN to prefix every granted byte with a tag byte (0xA0 | id).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          data_ack,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          ack_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [CW-1:0]         cnt;
    logic [NUM_REQ-1:0]    rr_grant;
    logic [IW-1:0]         rr_idx;
    logic                  rr_any;
    logic                  in_send;
    logic                  timeout;

    uart_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .last    (grant_id),
        .grant   (rr_grant),
        .idx     (rr_idx),
        .any_req (rr_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (rr_grant[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign in_send   = is_send_state(state);
    assign timeout   = in_send && !data_ack && (cnt == CW'(ACK_TIMEOUT - 1));
    assign tx_start  = in_send;
    assign arb_busy  = (state != ST_IDLE);
    assign req_ready = (state == ST_IDLE) ? rr_grant : '0;

`ifdef UART_ARB_TAG_EN
    logic [DATA_WIDTH-1:0] tag_byte;
    assign tag_byte = DATA_WIDTH'(TAG_BASE) | DATA_WIDTH'(grant_id);
    assign tx_data  = (state == ST_TAG_SEND) ? tag_byte : data_q;
`else
    assign tx_data  = data_q;
`endif

    // A timeout in either send state abandons the whole grant.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
`ifdef UART_ARB_TAG_EN
                if (rr_any) state_nxt = ST_TAG_SEND;
`else
                if (rr_any) state_nxt = ST_SEND;
`endif
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_SEND: begin
                if (data_ack)     state_nxt = ST_TAG_DRAIN;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_TAG_DRAIN: if (!tx_busy) state_nxt = ST_SEND;
`endif
            ST_SEND: begin
                if (data_ack)     state_nxt = ST_DRAIN;
                else if (timeout) state_nxt = ST_IDLE;
            end
            ST_DRAIN: if (!tx_busy) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            data_q   <= '0;
            grant_id <= IW'(NUM_REQ - 1);
            cnt      <= '0;
            ack_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && rr_any) begin
                data_q   <= sel_data;
                grant_id <= rr_idx;
            end
            if (timeout) ack_err <= 1'b1;
            // Counter restarts on every entry to a send state.
            if (in_send && state_nxt == state) cnt <= cnt + 1'b1;
            else                               cnt <= '0;
        end
    end

endmodule
